// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter slice.
// Holds the arbiter state encoding, default sizing values and a helper that
// returns a safe index/counter width for a given range.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CS_GAP_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF = 1024;

  // Watchdog counter width for the default timeout.
  localparam int unsigned CNT_W_DEF = $clog2(TIMEOUT_DEF);

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared resource.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - index that has highest priority this round
//   gnt_o   - one-hot winner (all zero when nothing is requested)
//   valid_o - at least one request is pending
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  int               sum;
  logic [PTR_W-1:0] idx;

  // Scan from the pointer upwards, wrapping, and keep the first hit.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      sum = int'(ptr_i) + i;
      if (sum >= int'(NUM_REQ)) sum = sum - int'(NUM_REQ);
      idx = PTR_W'(sum);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between NUM_REQ requesters, one transaction at a time.
// Sequences the master start/ready handshake, owns chip-select, enforces a
// minimum chip-select high gap and aborts hung transfers with a watchdog.
// Ports:
//   clk_i, rstn_i            - clock, asynchronous active-low reset
//   req_i/rw_i/wdata_i       - per-requester request, direction, write word
//   gnt_o/done_o/err_o       - per-requester grant, completion, timeout pulse
//   rdata_o                  - word read back, valid with done_o
//   spi_rw_o/spi_data_o      - latched direction/word presented to the master
//   spi_start_o/spi_ready_i  - start request to / idle status from the master
//   spi_rdata_i              - received word from the master
//   cs_n_o                   - slave chip-select, active low
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CS_GAP  = CS_GAP_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        rw_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      spi_rw_o,
  output logic [DATA_W-1:0]         spi_data_o,
  output logic                      spi_start_o,
  input  logic                      spi_ready_i,
  input  logic [DATA_W-1:0]         spi_rdata_i,
  output logic                      cs_n_o
);

  localparam int unsigned PTR_W = idx_width(NUM_REQ);
  // One counter serves both the watchdog and the chip-select gap.
  localparam int unsigned CNT_W = idx_width((TIMEOUT > CS_GAP) ? TIMEOUT : CS_GAP);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                cs_n_q, cs_n_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic                arb_valid;
  logic [PTR_W-1:0]    sel_idx;
  logic                sel_rw;
  logic [DATA_W-1:0]   sel_data;
  logic [PTR_W-1:0]    ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Turn the one-hot winner into an index and pick its direction and word.
  always_comb begin
    sel_idx  = '0;
    sel_rw   = 1'b0;
    sel_data = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (arb_gnt[k]) begin
        sel_idx  = PTR_W'(k);
        sel_rw   = rw_i[k];
        sel_data = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  // Normal completion in BUSY wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    data_d  = data_q;
    cs_n_d  = cs_n_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid && spi_ready_i) begin
          gnt_d   = arb_gnt;
          win_d   = sel_idx;
          rw_d    = sel_rw;
          data_d  = sel_data;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (cnt_q == TO_LAST) begin
          state_d = GAP;
          done_d  = gnt_q;
          err_d   = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!spi_ready_i) state_d = BUSY;
        end
      end
      BUSY: begin
        if (spi_ready_i) begin
          state_d = GAP;
          done_d  = gnt_q;
          rdata_d = spi_rdata_i;
        end else if (cnt_q == TO_LAST) begin
          state_d = GAP;
          done_d  = gnt_q;
          err_d   = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every way into GAP releases the bus and advances the pointer.
    if ((state_q != GAP) && (state_d == GAP)) begin
      gnt_d  = '0;
      cs_n_d = 1'b1;
      cnt_d  = '0;
      ptr_d  = ptr_next;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign spi_rw_o    = rw_q;
  assign spi_data_o  = data_q;
  assign spi_start_o = (state_q == LAUNCH);
  assign cs_n_o      = cs_n_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter with a simple SPI master model and a
// round-robin reference model for the expected winner of each transaction.
module tb_spi_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int CS_GAP  = 4;
  localparam int TIMEOUT = 64;

  logic                      clk_i = 1'b0;
  logic                      rstn_i;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        rw_i;
  logic [NUM_REQ*DATA_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]        gnt_o, done_o, err_o;
  logic [DATA_W-1:0]         rdata_o, spi_data_o, spi_rdata_i;
  logic                      spi_rw_o, spi_start_o, spi_ready_i, cs_n_o;

  int              checks = 0;
  int              errors = 0;
  int              modelPtr = 0;
  logic [DATA_W-1:0] modelRdata = '0;
  int              masterMode = 0;   // 0 normal, 1 never leaves idle, 2 forced busy
  int              masterLat = 16;
  logic [DATA_W-1:0] slaveWord = '0;
  bit              masterAbort = 1'b0;
  int              csViol = 0;
  int              overlapViol = 0;

  spi_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .CS_GAP  (CS_GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (req_i),
    .rw_i        (rw_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .spi_rw_o    (spi_rw_o),
    .spi_data_o  (spi_data_o),
    .spi_start_o (spi_start_o),
    .spi_ready_i (spi_ready_i),
    .spi_rdata_i (spi_rdata_i),
    .cs_n_o      (cs_n_o)
  );

  always #5 clk_i = ~clk_i;

  // Master model: accepts a start while idle, stays busy masterLat cycles,
  // then returns to idle presenting the slave word.
  initial begin
    int busyLeft;
    busyLeft    = 0;
    spi_ready_i = 1'b1;
    spi_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (masterAbort) begin
        busyLeft    = 0;
        masterAbort = 1'b0;
        spi_ready_i = 1'b1;
      end else if (masterMode == 1) begin
        busyLeft    = 0;
        spi_ready_i = 1'b1;
      end else if (masterMode == 2) begin
        busyLeft    = 0;
        spi_ready_i = 1'b0;
      end else if (busyLeft > 0) begin
        busyLeft = busyLeft - 1;
        if (busyLeft == 0) begin
          spi_ready_i = 1'b1;
          spi_rdata_i = slaveWord;
        end
      end else if (spi_start_o && spi_ready_i) begin
        spi_ready_i = 1'b0;
        busyLeft    = masterLat;
      end else begin
        spi_ready_i = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  // Round-robin rule: first set request at or after the pointer, wrapping.
  function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (((r >> ((p + i) % NUM_REQ)) & 1) != 0) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] rwv,
                               input logic [NUM_REQ*DATA_W-1:0] wd);
    req_i   = r;
    rw_i    = rwv;
    wdata_i = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitGrant(output int c);
    c = 0;
    while (gnt_o == '0 && c < 200) begin
      tick;
      c++;
    end
  endtask

  task automatic waitDone(output int c);
    c = 0;
    while (done_o == '0 && c < TIMEOUT + 20) begin
      tick;
      c++;
      if (done_o == '0 && cs_n_o !== 1'b0) csViol++;
      if ($countones(gnt_o) > 1) overlapViol++;
    end
  endtask

  // Issue a request from IDLE and check the grant one cycle later.
  task automatic startTxn(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] rwv,
                          input logic [NUM_REQ*DATA_W-1:0] wd, input logic [DATA_W-1:0] sw,
                          input string tag, output int w);
    slaveWord = sw;
    applyStimulus(r, rwv, wd);
    w = pick(r, modelPtr);
    tick;
    checkOutput({tag, "_gnt"}, 32'(gnt_o), 32'(1) << w);
    checkOutput({tag, "_rw"}, 32'(spi_rw_o), 32'((rwv >> w) & 1));
    checkOutput({tag, "_data"}, 32'(spi_data_o), 32'(DATA_W'(wd >> (w * DATA_W))));
    checkOutput({tag, "_cs_low"}, 32'(cs_n_o), 32'(0));
    checkOutput({tag, "_start"}, 32'(spi_start_o), 32'(1));
  endtask

  // Disturb inputs after grant, wait for completion, then run out the gap.
  task automatic finishTxn(input int w, input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] rwv,
                           input logic [NUM_REQ*DATA_W-1:0] wd, input logic [DATA_W-1:0] sw,
                           input string tag);
    int c;
    int gapViol;
    csViol = 0;
    applyStimulus(r & NUM_REQ'($urandom), NUM_REQ'($urandom), (NUM_REQ*DATA_W)'($urandom));
    waitDone(c);
    checkOutput({tag, "_done"}, 32'(done_o), 32'(1) << w);
    checkOutput({tag, "_err"}, 32'(err_o), 32'(0));
    checkOutput({tag, "_rdata"}, 32'(rdata_o), 32'(sw));
    checkOutput({tag, "_data_held"}, 32'(spi_data_o), 32'(DATA_W'(wd >> (w * DATA_W))));
    checkOutput({tag, "_rw_held"}, 32'(spi_rw_o), 32'((rwv >> w) & 1));
    checkOutput({tag, "_cs_low_during"}, 32'(csViol), 32'(0));
    modelRdata = sw;
    modelPtr   = (w + 1) % NUM_REQ;
    applyStimulus('0, '0, '0);
    tick;
    checkOutput({tag, "_single_pulse"}, 32'({done_o, err_o}), 32'(0));
    gapViol = 0;
    for (int i = 1; i < CS_GAP; i++) begin
      if (cs_n_o !== 1'b1 || gnt_o !== '0) gapViol++;
      tick;
    end
    checkOutput({tag, "_gap_cs_high"}, 32'(gapViol), 32'(0));
  endtask

  initial begin
    int w;
    int c;
    int doneSeen;
    logic [NUM_REQ-1:0] r;
    logic [NUM_REQ-1:0] rwv;
    logic [NUM_REQ*DATA_W-1:0] wd;
    logic [DATA_W-1:0] sw;

    rstn_i = 1'b0;
    applyStimulus('0, '0, '0);
    repeat (3) tick;
    checkOutput("reset_gnt_done_err", 32'({gnt_o, done_o, err_o}), 32'(0));
    checkOutput("reset_cs_n", 32'(cs_n_o), 32'(1));
    checkOutput("reset_spi_out", 32'({spi_start_o, spi_rw_o, spi_data_o, rdata_o}), 32'(0));
    rstn_i = 1'b1;
    tick;

    $display("[TB] single write");
    masterLat = 16;
    startTxn(2'b01, 2'b00, 16'h000F, 8'h3C, "wr", w);
    finishTxn(w, 2'b01, 2'b00, 16'h000F, 8'h3C, "wr");

    $display("[TB] read from requester 1");
    startTxn(2'b10, 2'b10, 16'h5500, 8'hA5, "rd", w);
    finishTxn(w, 2'b10, 2'b10, 16'h5500, 8'hA5, "rd");

    $display("[TB] contention");
    overlapViol = 0;
    applyStimulus(2'b11, 2'b01, 16'hB7C3);
    for (int t = 0; t < 4; t++) begin
      sw = DATA_W'($urandom);
      slaveWord = sw;
      waitGrant(c);
      checkOutput("cont_latency", 32'(c), (t == 0) ? 32'(1) : 32'(CS_GAP + 1));
      w = pick(2'b11, modelPtr);
      checkOutput("cont_order", 32'(gnt_o), 32'(1) << w);
      waitDone(c);
      checkOutput("cont_done", 32'(done_o), 32'(1) << w);
      checkOutput("cont_rdata", 32'(rdata_o), 32'(sw));
      modelRdata = sw;
      modelPtr = (w + 1) % NUM_REQ;
    end
    checkOutput("cont_overlap", 32'(overlapViol), 32'(0));
    applyStimulus('0, '0, '0);
    repeat (CS_GAP) tick;

    $display("[TB] watchdog timeout");
    masterMode = 1;
    applyStimulus(2'b01, 2'b00, 16'h0042);
    w = pick(2'b01, modelPtr);
    tick;
    checkOutput("to_gnt", 32'(gnt_o), 32'(1) << w);
    csViol = 0;
    waitDone(c);
    checkOutput("to_latency", 32'(c), 32'(TIMEOUT));
    checkOutput("to_done_err", 32'({done_o, err_o}), {30'(0), 2'b01} << w | {30'(0), 2'b01} << (w + NUM_REQ));
    checkOutput("to_rdata_kept", 32'(rdata_o), 32'(modelRdata));
    checkOutput("to_cs_high", 32'({cs_n_o, spi_start_o}), 32'(2));
    modelPtr = (w + 1) % NUM_REQ;
    masterMode = 0;
    applyStimulus('0, '0, '0);
    repeat (CS_GAP) tick;
    startTxn(2'b10, 2'b00, 16'h9900, 8'h17, "after_to", w);
    finishTxn(w, 2'b10, 2'b00, 16'h9900, 8'h17, "after_to");

    $display("[TB] master busy at idle");
    masterMode = 2;
    tick;
    applyStimulus(2'b01, 2'b01, 16'h00E1);
    doneSeen = 0;
    repeat (5) begin
      tick;
      if (gnt_o !== '0) doneSeen++;
    end
    checkOutput("busy_no_gnt", 32'(doneSeen), 32'(0));
    masterMode = 0;
    w = pick(2'b01, modelPtr);
    slaveWord = 8'h6B;
    tick;
    checkOutput("busy_gnt_after_ready", 32'(gnt_o), 32'(1) << w);
    finishTxn(w, 2'b01, 2'b01, 16'h00E1, 8'h6B, "busy");

    $display("[TB] reset mid-busy");
    masterLat = 20;
    startTxn(2'b10, 2'b10, 16'hC800, 8'h5A, "rst", w);
    repeat (5) tick;
    checkOutput("rst_in_busy", 32'({spi_start_o, cs_n_o}), 32'(0));
    #2;
    rstn_i = 1'b0;
    masterAbort = 1'b1;
    #1;
    checkOutput("rst_async_gnt_done_err", 32'({gnt_o, done_o, err_o}), 32'(0));
    checkOutput("rst_async_cs_n", 32'(cs_n_o), 32'(1));
    checkOutput("rst_async_spi", 32'({spi_start_o, spi_rw_o, spi_data_o, rdata_o}), 32'(0));
    applyStimulus('0, '0, '0);
    repeat (2) tick;
    rstn_i = 1'b1;
    modelPtr = 0;
    modelRdata = '0;
    doneSeen = 0;
    repeat (40) begin
      tick;
      if (done_o !== '0) doneSeen++;
    end
    checkOutput("rst_no_done", 32'(doneSeen), 32'(0));

    $display("[TB] randomized transactions");
    for (int n = 0; n < 12; n++) begin
      r   = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      rwv = NUM_REQ'($urandom);
      wd  = (NUM_REQ*DATA_W)'($urandom);
      sw  = DATA_W'($urandom);
      masterLat = $urandom_range(2, 12);
      startTxn(r, rwv, wd, sw, "rand", w);
      finishTxn(w, r, rwv, wd, sw, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
